mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL provide parameter IO_ADDR, default 8'hFF, the single byte address mapped to the I/O port instead of data memory.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports req_valid in 1 (request present) and req_ready out 1 (unit idle, can accept).
REQ-005 SHALL have ports req_we in 1 (1=store, 0=load) and req_half in 1 (1=16-bit, 0=8-bit).
REQ-006 SHALL have ports req_addr in 8 (byte address) and req_wdata in 16 (store data, little-endian).
REQ-007 SHALL have ports rsp_valid out 1 (one-cycle completion strobe), rsp_rdata out 16 (load result) and rsp_err out 1 (request rejected).
REQ-008 SHALL have ports mem_a out 8, mem_wd out 8, mem_we out 1 and mem_rd in 8, driving the 256x8 data memory; mem_rd is combinational read data of mem_a.
REQ-009 SHALL have ports io_out out 8 (I/O output register) and io_in in 8 (I/O input, sampled on loads).

Function
REQ-010 SHALL implement FSM states IDLE, ACC0, ACC1, RESP; req_ready=1 only in IDLE.
REQ-011 SHALL accept a request on a rising edge with req_valid=1 and req_ready=1, capturing req_we, req_half, req_addr and req_wdata; later input changes SHALL have no effect.
REQ-012 Accept with req_half=1 and req_addr[0]=1 (misaligned) SHALL go directly to RESP with rsp_err=1 and perform no memory or I/O access.
REQ-013 All other accepts SHALL go to ACC0; ACC0 accesses captured addr with byte wdata[7:0].
REQ-014 From ACC0: half → ACC1 at addr+1 with wdata[15:8]; byte → RESP. ACC1 → RESP always.
REQ-015 mem_a, mem_wd, mem_we SHALL be combinational decodes of registered state; mem_we=1 only in ACC0/ACC1 of a store to a non-IO_ADDR address; in IDLE/RESP mem_we=0, mem_a=0, mem_wd=0.
REQ-016 Loads SHALL register mem_rd at the end of ACC0 into rsp_rdata[7:0] and at the end of ACC1 into rsp_rdata[15:8]; byte loads SHALL zero-extend (rsp_rdata[15:8]=0).
REQ-017 An access at IO_ADDR SHALL not assert mem_we; a store SHALL load io_out with the byte at the end of that access cycle; a load SHALL return io_in instead of mem_rd.
REQ-018 RESP SHALL last exactly one cycle with rsp_valid=1, then return to IDLE; rsp_err=0 for accepted accesses.
REQ-019 Latency: byte rsp_valid high in cycle N+1 after accept edge N; half in N+2; misaligned in N.
REQ-020 rsp_rdata SHALL hold its value until overwritten by the next load; stores and errors SHALL leave rsp_rdata unchanged.
REQ-021 Even halfword addresses SHALL never wrap (max addr+1=8'hFF); no address arithmetic beyond 8 bits.
REQ-022 req_valid asserted outside IDLE SHALL be ignored (not queued).

Reset
REQ-023 rst=0 SHALL asynchronously force state IDLE, rsp_valid=0, rsp_err=0, rsp_rdata=0, io_out=0, so mem_we=0 immediately.
REQ-024 Reset mid-operation SHALL abort the request with no response; partially performed writes are not rolled back.

Configuration
REQ-025 Macro MAU_HALFWORD_EN defined: halfword support as above.
REQ-026 MAU_HALFWORD_EN undefined: req_half ignored, every request is a byte access, ACC1 and misalignment error are not built, rsp_err permanently 0.

Verification
REQ-027 Byte store addr 8'h10 data 16'h00A5, then byte load 8'h10 → mem_we pulse 1 cycle with mem_a=10, mem_wd=A5; load rsp_rdata=16'h00A5, rsp_valid at N+1.
REQ-028 Half store addr 8'h20 data 16'hBEEF, half load 8'h20 → writes EF@20, BE@21; load rsp_rdata=16'hBEEF at N+2.
REQ-029 Half load addr 8'h21 → rsp_valid and rsp_err=1 in cycle N, mem_we never asserted, rsp_rdata unchanged.
REQ-030 Byte store 8'hFF data 8'h3C, io_in=8'h77, byte load 8'hFF → io_out=3C, mem_we stays 0, rsp_rdata=16'h0077.
REQ-031 Assert rst=0 during ACC1 of a half store → mem_we drops immediately, no rsp_valid, req_ready=1 after release, io_out=0.

Source files
------------

// File: rtl/mem_access_unit.sv
// Purpose : byte/halfword load-store unit in front of a 256x8 data memory, with one
//           memory-mapped I/O byte at IO_ADDR (io_out register for stores, io_in for loads).
// Latency : response one cycle after the accept edge for byte accesses and two cycles for
//           halfword accesses. A misaligned halfword responds in the cycle right after accept.
// Backpressure: req_ready is high only while idle. Requests offered while busy are dropped,
//           not queued.
// Build option: define MAU_HALFWORD_EN to build 16-bit accesses and the misalignment error.
//           Without it, req_half is ignored and rsp_err is tied to 0.
// Ports   : clk/rst (async, active-low); req_valid/req_ready/req_we/req_half/req_addr/req_wdata
//           request side; rsp_valid/rsp_rdata/rsp_err response side; mem_a/mem_wd/mem_we/mem_rd
//           memory side; io_out/io_in I/O port.
module mem_access_unit #(
  parameter logic [7:0] IO_ADDR = 8'hFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic        req_half,
  input  logic [7:0]  req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic [7:0]  mem_a,
  output logic [7:0]  mem_wd,
  output logic        mem_we,
  input  logic [7:0]  mem_rd,
  output logic [7:0]  io_out,
  input  logic [7:0]  io_in
);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

  state_t      state, state_nxt;
  logic        we_q;
  logic        half_q;
  logic [7:0]  addr_q;
  logic [15:0] wdata_q;
  logic        req_mis;
  logic        in_acc;
  logic [7:0]  cur_addr;
  logic [7:0]  cur_byte;
  logic        cur_io;
  logic [7:0]  rd_byte;

`ifdef MAU_HALFWORD_EN
  logic err_q;

  assign req_mis = req_half & req_addr[0];
  assign rsp_err = (state == RESP) & err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      half_q <= 1'b0;
      err_q  <= 1'b0;
    end else if (state == IDLE && req_valid) begin
      half_q <= req_half;
      err_q  <= req_mis;
    end
  end
`else
  // Byte-only build: req_half is accepted on the port but has no effect.
  logic unused_half;
  assign unused_half = req_half;
  assign half_q      = 1'b0;
  assign req_mis     = 1'b0;
  assign rsp_err     = 1'b0;
`endif

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);

  // Address/data of the byte being accessed this cycle. Even halfwords top out at
  // FE+1 = FF, so the 8-bit increment never wraps for an accepted access.
  assign in_acc   = (state == ACC0) || (state == ACC1);
  assign cur_addr = (state == ACC1) ? (addr_q + 8'd1) : addr_q;
  assign cur_byte = (state == ACC1) ? wdata_q[15:8] : wdata_q[7:0];
  assign cur_io   = (cur_addr == IO_ADDR);
  assign rd_byte  = cur_io ? io_in : mem_rd;

  assign mem_a  = in_acc ? cur_addr : 8'h00;
  assign mem_wd = in_acc ? cur_byte : 8'h00;
  assign mem_we = in_acc & we_q & ~cur_io;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req_valid) state_nxt = req_mis ? RESP : ACC0;
      ACC0: state_nxt = half_q ? ACC1 : RESP;
`ifdef MAU_HALFWORD_EN
      ACC1: state_nxt = RESP;
`endif
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture. Only the idle-state handshake loads these, so later input changes are inert.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q    <= 1'b0;
      addr_q  <= 8'h00;
      wdata_q <= 16'h0000;
    end else if (state == IDLE && req_valid) begin
      we_q    <= req_we;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  // Load data and I/O output register, updated at the end of each access cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_rdata <= 16'h0000;
      io_out    <= 8'h00;
    end else if (in_acc) begin
      if (we_q) begin
        if (cur_io) io_out <= cur_byte;
      end else if (state == ACC0) begin
        // A halfword keeps the old upper byte until ACC1 replaces it. A byte load zero-extends.
        if (half_q) rsp_rdata[7:0] <= rd_byte;
        else        rsp_rdata      <= {8'h00, rd_byte};
      end else begin
        rsp_rdata[15:8] <= rd_byte;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

`ifdef MAU_HALFWORD_EN
  localparam bit HW = 1'b1;
`else
  localparam bit HW = 1'b0;
`endif
  localparam logic [7:0] IO = 8'hFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_half;
  logic [7:0]  req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid, rsp_err;
  logic [15:0] rsp_rdata;
  logic [7:0]  mem_a, mem_wd, mem_rd, io_out, io_in;
  logic        mem_we;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.IO_ADDR(IO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_half(req_half),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd),
    .io_out(io_out), .io_in(io_in)
  );

  // Data memory attached to the DUT: combinational read, write on the clock edge.
  logic [7:0] ram [256];
  assign mem_rd = ram[mem_a];
  always @(posedge clk) if (mem_we) ram[mem_a] <= mem_wd;

  // Reference model state.
  logic [7:0]  m_mem [256];
  logic [7:0]  m_io;
  logic [15:0] m_rdata;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  // Model: a request is a list of byte transfers at addr, addr+1, ...
  task automatic model(input logic we, input logic half, input logic [7:0] addr,
                       input logic [15:0] wd, input logic [7:0] ioin,
                       output int lat, output int wcnt, output logic err);
    bit h;
    int n;
    logic [7:0] a, b;
    h = HW && half;
    err = h && addr[0];
    wcnt = 0;
    lat = 0;
    if (!err) begin
      n = h ? 2 : 1;
      lat = n;
      if (!we) m_rdata = 16'h0000;
      for (int i = 0; i < n; i++) begin
        a = addr + 8'(i);
        b = (i == 0) ? wd[7:0] : wd[15:8];
        if (a == IO) begin
          if (we) m_io = b;
          else    m_rdata[8*i +: 8] = ioin;
        end else if (we) begin
          m_mem[a] = b;
          wcnt++;
        end else begin
          m_rdata[8*i +: 8] = m_mem[a];
        end
      end
    end
  endtask

  // Issues one request. While the unit is busy, it keeps req_valid high with junk,
  // which must be ignored. It counts mem_we cycles and cycles to rsp_valid.
  task automatic run_req(input logic we, input logic half, input logic [7:0] addr,
                         input logic [15:0] wd, input logic [7:0] ioin,
                         output int lat, output int wcnt, output logic err);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_half = half; req_addr = addr; req_wdata = wd;
    io_in = ioin;
    @(posedge clk); #1;
    req_we = 1'($urandom); req_half = 1'($urandom);
    req_addr = 8'($urandom); req_wdata = 16'($urandom);
    lat = -1; wcnt = 0; err = 1'bx;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (mem_we) wcnt++;
      if (rsp_valid) begin
        lat = c;
        err = rsp_err;
        break;
      end
    end
    req_valid = 1'b0;
  endtask

  task automatic post_idle();
    @(negedge clk);
    chk("idle_ready", 32'(req_ready), 32'd1);
    chk("idle_no_rsp", 32'(rsp_valid), 32'd0);
  endtask

  typedef struct {
    logic        we, half;
    logic [7:0]  addr;
    logic [15:0] wd;
    logic [7:0]  ioin;
    logic [15:0] rdata;
    logic        err;
    int          lat;
    logic [7:0]  io;
    int          wcnt;
  } vec_t;

  function automatic vec_t mk(logic we, logic half, logic [7:0] addr, logic [15:0] wd,
                              logic [7:0] ioin, logic [15:0] rdata, logic err, int lat,
                              logic [7:0] io, int wcnt);
    vec_t v;
    v.we = we; v.half = half; v.addr = addr; v.wd = wd; v.ioin = ioin;
    v.rdata = rdata; v.err = err; v.lat = lat; v.io = io; v.wcnt = wcnt;
    return v;
  endfunction

  initial begin
    vec_t tbl [9];
    int lat, wcnt, mlat, mwcnt;
    logic err, merr;
    logic [7:0] ra;
    logic rwe, rhalf;
    logic [15:0] rwd;
    logic [7:0] rio;
    int mem_bad;

    for (int i = 0; i < 256; i++) begin ram[i] = 8'h00; m_mem[i] = 8'h00; end
    m_io = 8'h00; m_rdata = 16'h0000;
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_half = 1'b0;
    req_addr = 8'h00; req_wdata = 16'h0000; io_in = 8'h00;

    // Reset state
    #3;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_rdata", 32'(rsp_rdata), 32'h0);
    chk("rst_io_out", 32'(io_out), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_a", 32'(mem_a), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Directed table. Expectations follow the build (halfword or byte-only).
    tbl[0] = mk(1, 0, 8'h10, 16'h00A5, 8'h00, 16'h0000, 0, 1, 8'h00, 1);
    tbl[1] = mk(0, 0, 8'h10, 16'h0000, 8'h00, 16'h00A5, 0, 1, 8'h00, 0);
    tbl[2] = mk(1, 1, 8'h20, 16'hBEEF, 8'h00, 16'h00A5, 0, HW ? 2 : 1, 8'h00, HW ? 2 : 1);
    tbl[3] = mk(0, 1, 8'h20, 16'h0000, 8'h00, HW ? 16'hBEEF : 16'h00EF, 0, HW ? 2 : 1, 8'h00, 0);
    tbl[4] = mk(0, 1, 8'h21, 16'h0000, 8'h00, HW ? 16'hBEEF : 16'h0000, HW, HW ? 0 : 1, 8'h00, 0);
    tbl[5] = mk(1, 0, 8'hFF, 16'h003C, 8'h00, HW ? 16'hBEEF : 16'h0000, 0, 1, 8'h3C, 0);
    tbl[6] = mk(0, 0, 8'hFF, 16'h0000, 8'h77, 16'h0077, 0, 1, 8'h3C, 0);
    tbl[7] = mk(0, 1, 8'hFE, 16'h0000, 8'h5A, HW ? 16'h5A00 : 16'h0000, 0, HW ? 2 : 1, 8'h3C, 0);
    tbl[8] = mk(1, 1, 8'hFE, 16'h1234, 8'h00, HW ? 16'h5A00 : 16'h0000, 0, HW ? 2 : 1,
                HW ? 8'h12 : 8'h3C, 1);

    for (int i = 0; i < 9; i++) begin
      run_req(tbl[i].we, tbl[i].half, tbl[i].addr, tbl[i].wd, tbl[i].ioin, lat, wcnt, err);
      model(tbl[i].we, tbl[i].half, tbl[i].addr, tbl[i].wd, tbl[i].ioin, mlat, mwcnt, merr);
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(tbl[i].lat));
      chk($sformatf("vec%0d_err", i), 32'(err), 32'(tbl[i].err));
      chk($sformatf("vec%0d_rdata", i), 32'(rsp_rdata), 32'(tbl[i].rdata));
      chk($sformatf("vec%0d_io_out", i), 32'(io_out), 32'(tbl[i].io));
      chk($sformatf("vec%0d_writes", i), 32'(wcnt), 32'(tbl[i].wcnt));
      post_idle();
    end

    // Reset during the last access cycle of a store (ACC1 for halfwords)
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_half = 1'b1; req_addr = 8'h30; req_wdata = 16'h5566;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    if (HW) @(negedge clk);
    chk("mid_mem_we_before", 32'(mem_we), 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_mem_we_after", 32'(mem_we), 32'd0);
    chk("mid_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_io_out", 32'(io_out), 32'h0);
    chk("mid_rdata", 32'(rsp_rdata), 32'h0);
    if (HW) m_mem[8'h30] = 8'h66;
    m_io = 8'h00; m_rdata = 16'h0000;
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("mid_ready_after", 32'(req_ready), 32'd1);
      chk("mid_no_rsp_after", 32'(rsp_valid), 32'd0);
    end

    // Randomised traffic against the model
    for (int i = 0; i < 200; i++) begin
      rwe = 1'($urandom); rhalf = 1'($urandom);
      case ($urandom_range(0, 3))
        0: ra = 8'hFE | 8'($urandom_range(0, 1));
        1: ra = 8'h40 | 8'($urandom_range(0, 7));
        default: ra = 8'($urandom);
      endcase
      rwd = 16'($urandom); rio = 8'($urandom);
      run_req(rwe, rhalf, ra, rwd, rio, lat, wcnt, err);
      model(rwe, rhalf, ra, rwd, rio, mlat, mwcnt, merr);
      chk("rnd_lat", 32'(lat), 32'(mlat));
      chk("rnd_err", 32'(err), 32'(merr));
      chk("rnd_rdata", 32'(rsp_rdata), 32'(m_rdata));
      chk("rnd_io_out", 32'(io_out), 32'(m_io));
      chk("rnd_writes", 32'(wcnt), 32'(mwcnt));
      post_idle();
    end

    // Final memory contents
    mem_bad = 0;
    for (int i = 0; i < 256; i++) if (ram[i] !== m_mem[i]) mem_bad++;
    chk("mem_contents_bad_bytes", 32'(mem_bad), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
